// File: rtl/riscv_prefetch_pkg.sv
// Shared types and helpers for the RISC-V instruction prefetch queue.
// PREFETCH_ERR_EN adds a stored fetch-error bit to every queue entry.
package riscv_prefetch_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
`ifdef PREFETCH_ERR_EN
    logic        err;
`endif
  } fetch_entry_t;

  // Bits needed to hold a count in the range 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/riscv_prefetch_fifo.sv
// Power-of-two entry FIFO for fetched instructions; clear flushes all entries.
module riscv_prefetch_fifo
  import riscv_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           push,
  input  logic                           pop,
  input  fetch_entry_t                   wdata,
  output fetch_entry_t                   rdata,
  output logic [cnt_width(DEPTH)-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !clr && (count != CW'(DEPTH));
  assign do_pop  = pop && !clr && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/riscv_prefetch_queue.sv
// Instruction prefetch queue: credit-limited fetch requests, branch flush with
// in-flight discard, FIFO of responses. Optional error tracking: PREFETCH_ERR_EN.
module riscv_prefetch_queue
  import riscv_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_W = CW'(MAX_OUTSTANDING);

  fetch_state_e  state_q;
  logic [CW-1:0] outstanding_cnt;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [31:0]   fetch_addr_q;
  logic [31:0]   rsp_addr_q;
  logic [31:0]   branch_addr;
  logic          init_q;
  logic          credit_ok;
  logic          issue_ok;
  logic          gnt;
  logic          rvalid_eff;
  logic          push;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [1:0]    unused_addr_lsb;

  assign unused_addr_lsb = addr_i[1:0];
  assign branch_addr     = {addr_i[31:2], 2'b00};
  assign credit_ok       = (({1'b0, outstanding_cnt} + {1'b0, fifo_cnt}) < DEPTH_W)
                           && (outstanding_cnt < MAX_OUT_W);

  // A pending request is never withdrawn; new ones need credit. Held off during
  // reset and for the first cycle after it.
  always_comb begin
    instr_req_o = 1'b0;
    if (!rst && !init_q) begin
      if (state_q == WAIT_GNT) instr_req_o = 1'b1;
      else                     instr_req_o = req_i && credit_ok && issue_ok;
    end
  end

  assign instr_addr_o = branch_i ? branch_addr : fetch_addr_q;
  assign gnt          = instr_req_o && instr_gnt_i;
  // Responses with nothing outstanding (stale across reset) are ignored.
  assign rvalid_eff   = instr_rvalid_i && (outstanding_cnt != '0);
  assign push         = rvalid_eff && (discard_cnt == '0) && !branch_i;

  always_ff @(posedge clk) begin
    init_q <= rst;
    if (rst) begin
      state_q         <= IDLE;
      outstanding_cnt <= '0;
      discard_cnt     <= '0;
      fetch_addr_q    <= '0;
      rsp_addr_q      <= '0;
    end else begin
      case (state_q)
        IDLE:     if (instr_req_o && !instr_gnt_i) state_q <= WAIT_GNT;
        WAIT_GNT: if (instr_gnt_i) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase

      outstanding_cnt <= outstanding_cnt + CW'(gnt) - CW'(rvalid_eff);

      if (gnt)           fetch_addr_q <= instr_addr_o + 32'd4;
      else if (branch_i) fetch_addr_q <= branch_addr;

      // Everything in flight before the branch cycle belongs to the old stream.
      if (branch_i) begin
        rsp_addr_q  <= branch_addr;
        discard_cnt <= outstanding_cnt - CW'(rvalid_eff);
      end else begin
        if (push) rsp_addr_q <= rsp_addr_q + 32'd4;
        if (rvalid_eff && (discard_cnt != '0)) discard_cnt <= discard_cnt - CW'(1);
      end
    end
  end

`ifdef PREFETCH_ERR_EN
  logic err_block_q;

  // After an errored fetch is queued, stop fetching until the next redirect.
  always_ff @(posedge clk) begin
    if (rst || branch_i)          err_block_q <= 1'b0;
    else if (push && instr_err_i) err_block_q <= 1'b1;
  end

  assign issue_ok   = !err_block_q || branch_i;
  assign push_entry = '{rdata: instr_rdata_i, addr: rsp_addr_q, err: instr_err_i};
  assign err_o      = valid_o && head.err;
`else
  logic unused_err;

  assign unused_err = instr_err_i;
  assign issue_ok   = 1'b1;
  assign push_entry = '{rdata: instr_rdata_i, addr: rsp_addr_q};
  assign err_o      = 1'b0;
`endif

  riscv_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (branch_i),
    .push  (push),
    .pop   (ready_i && valid_o),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_cnt)
  );

  assign valid_o = !rst && (fifo_cnt != '0);
  assign rdata_o = head.rdata;
  assign addr_o  = head.addr;
  assign busy_o  = !rst && ((outstanding_cnt != '0) || instr_req_o);

endmodule

// File: tb/tb_riscv_prefetch_queue.sv
// Scoreboard bench for riscv_prefetch_queue (default DEPTH=4, MAX_OUTSTANDING=2);
// error-path expectations follow PREFETCH_ERR_EN.
module tb_riscv_prefetch_queue;

  localparam logic [31:0] ERR_ADDR = 32'h0000_010C;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        busy_o;

  always #5 clk = ~clk;

  riscv_prefetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .err_o          (err_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_req_t;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  mem_req_t    pend[$];
  exp_t        exp_q[$];
  logic [31:0] popped[$];
  logic        pop_err[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          model_out = 0;
  int          n_gnt = 0;
  int          lat = 1;
  logic        gnt_en = 1'b0;
  logic        err_on = 1'b0;
  logic        err_seen = 1'b0;
  logic        post_rst = 1'b0;
  logic [31:0] next_fetch = '0;
  logic        s_req, s_valid, s_busy, s_err;
  logic [31:0] s_iaddr, s_addr_o;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_F00D;
  endfunction

  function automatic logic err_exp(input logic [31:0] a);
`ifdef PREFETCH_ERR_EN
    return err_on && (a == ERR_ADDR);
`else
    return 1'b0 && (a == ERR_ADDR);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock cycle: drive the memory side, sample, update the model, advance.
  task automatic tick();
    mem_req_t m;
    exp_t     e;
    logic     rv_ok;
    instr_gnt_i    = gnt_en;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_word(pend[0].addr);
      instr_err_i    = err_on && (pend[0].addr == ERR_ADDR);
    end
    #1;
    s_req = instr_req_o; s_valid = valid_o; s_busy = busy_o; s_err = err_o;
    s_iaddr = instr_addr_o; s_addr_o = addr_o;
    if (rst) begin
      chk("rst_req", 32'(instr_req_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      exp_q.delete();
      model_out = 0; next_fetch = '0; epoch++; post_rst = 1'b1; err_seen = 1'b0;
      if (instr_rvalid_i) m = pend.pop_front();
    end else begin
      if (post_rst) chk("post_rst_req", 32'(instr_req_o), 32'd0);
      post_rst = 1'b0;
      chk("valid", 32'(valid_o), 32'(exp_q.size() != 0));
      if (model_out != 0) chk("busy", 32'(busy_o), 32'd1);
`ifdef PREFETCH_ERR_EN
      if (err_seen && !branch_i) chk("err_no_req", 32'(instr_req_o), 32'd0);
`endif
      if (valid_o && ready_i && !branch_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("head_addr", addr_o, e.addr);
        chk("head_rdata", rdata_o, e.rdata);
        chk("head_err", 32'(err_o), 32'(e.err));
        popped.push_back(addr_o);
        pop_err.push_back(err_o);
      end
      if (branch_i) begin
        epoch++;
        exp_q.delete();
        next_fetch = {addr_i[31:2], 2'b00};
        err_seen = 1'b0;
      end
      if (instr_req_o) chk("instr_addr", instr_addr_o, next_fetch);
      rv_ok = instr_rvalid_i && (model_out > 0);
      if (instr_rvalid_i) begin
        m = pend.pop_front();
        if (rv_ok && m.epoch == epoch) begin
          exp_q.push_back('{rdata: mem_word(m.addr), addr: m.addr, err: err_exp(m.addr)});
          if (err_exp(m.addr)) err_seen = 1'b1;
        end
        if (rv_ok) model_out--;
      end
      if (instr_req_o && instr_gnt_i) begin
        pend.push_back('{addr: next_fetch, due: cyc + lat, epoch: epoch});
        next_fetch = next_fetch + 32'd4;
        model_out++;
        n_gnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_branch(input logic [31:0] a);
    branch_i = 1'b1;
    addr_i   = a;
    tick();
    branch_i = 1'b0;
  endtask

  // Stop fetching and collect everything in flight, within a cycle budget.
  task automatic drain();
    req_i = 1'b0; ready_i = 1'b1; gnt_en = 1'b1;
    for (int i = 0; i < 60 && (model_out != 0 || exp_q.size() != 0 || pend.size() != 0); i++)
      tick();
    chk("drain", 32'(model_out + exp_q.size() + pend.size()), 32'd0);
    tick();
    chk("idle_busy", 32'(s_busy), 32'd0);
  endtask

  initial begin
    int first_valid;
    logic [31:0] exp_addr;
    logic found;
    rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = '0; ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    repeat (2) tick();
    rst = 1'b0; req_i = 1'b1;
    tick();
    req_i = 1'b0;
    tick();
    chk("reset_idle_busy", 32'(s_busy), 32'd0);

    // Streaming after a redirect to 0x100.
    gnt_en = 1'b1; ready_i = 1'b1; lat = 1; req_i = 1'b1;
    popped.delete(); pop_err.delete();
    do_branch(32'h100);
    first_valid = s_valid ? 1 : 0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (s_valid && first_valid == 0) first_valid = i;
    end
    chk("s1_first_valid", 32'(first_valid), 32'd3);
    chk("s1_pops", 32'(popped.size() >= 3), 32'd1);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      chk("s1_addr_seq", popped[i], 32'h100 + 32'(4 * i));
    drain();

    // Back-pressure: credits cap grants at the FIFO depth.
    ready_i = 1'b0; req_i = 1'b1; gnt_en = 1'b1; lat = 1; n_gnt = 0;
    do_branch(32'h180);
    repeat (12) tick();
    chk("s2_grants", 32'(n_gnt), 32'd4);
    chk("s2_req_off", 32'(s_req), 32'd0);
    chk("s2_fifo_full", 32'(dut.fifo_cnt), 32'd4);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    repeat (8) tick();
    chk("s2_one_more", 32'(n_gnt), 32'd5);
    chk("s2_refilled", 32'(dut.fifo_cnt), 32'd4);
    drain();

    // Redirect with two requests in flight.
    lat = 3; req_i = 1'b1; ready_i = 1'b1; gnt_en = 1'b1;
    do_branch(32'h200);
    tick();
    chk("s3_busy", 32'(s_busy), 32'd1);
    do_branch(32'h300);
    for (int i = 0; i < 20 && !s_valid; i++) tick();
    chk("s3_valid_seen", 32'(s_valid), 32'd1);
    chk("s3_first_addr", s_addr_o, 32'h300);
    drain();

    // Grant held off for five cycles, redirect on the third.
    lat = 1; gnt_en = 1'b0; req_i = 1'b1; ready_i = 1'b1;
    exp_addr = next_fetch;
    tick();
    chk("s4_req1", 32'(s_req), 32'd1);
    chk("s4_addr1", s_iaddr, exp_addr);
    tick();
    chk("s4_addr2", s_iaddr, exp_addr);
    do_branch(32'h402);
    chk("s4_switch", s_iaddr, 32'h400);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("s4_hold_req", 32'(s_req), 32'd1);
      chk("s4_hold_addr", s_iaddr, 32'h400);
    end
    gnt_en = 1'b1;
    tick();
    chk("s4_granted_addr", s_iaddr, 32'h400);
    drain();

    // Fetch error reported at 0x10C.
    lat = 1; gnt_en = 1'b1; ready_i = 1'b1; req_i = 1'b1; err_on = 1'b1;
    popped.delete(); pop_err.delete(); n_gnt = 0;
    do_branch(32'h100);
    repeat (12) tick();
    found = 1'b0;
    for (int i = 0; i < popped.size(); i++) begin
      if (popped[i] == ERR_ADDR && !found) begin
        found = 1'b1;
`ifdef PREFETCH_ERR_EN
        chk("s5_err_o", 32'(pop_err[i]), 32'd1);
`else
        chk("s5_err_o", 32'(pop_err[i]), 32'd0);
`endif
      end
    end
    chk("s5_err_entry_seen", 32'(found), 32'd1);
`ifdef PREFETCH_ERR_EN
    chk("s5_blocked", 32'(s_req), 32'd0);
    chk("s5_grants", 32'(n_gnt), 32'd5);
`else
    chk("s5_still_fetching", 32'(s_req), 32'd1);
`endif
    do_branch(32'h500);
    chk("s5_resume", 32'(s_req), 32'd1);
    err_on = 1'b0;
    drain();

    // Reset with two requests in flight; late responses must be ignored.
    lat = 4; gnt_en = 1'b1; req_i = 1'b1; ready_i = 1'b1;
    do_branch(32'h600);
    tick();
    chk("s6_busy_before", 32'(s_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("s6_valid_after", 32'(s_valid), 32'd0);
    chk("s6_busy_after", 32'(s_busy), 32'd0);
    req_i = 1'b0;
    repeat (6) tick();
    chk("s6_no_push", 32'(dut.fifo_cnt), 32'd0);
    chk("s6_busy_idle", 32'(s_busy), 32'd0);
    chk("s6_late_done", 32'(pend.size()), 32'd0);

    // Normal fetching resumes after reset.
    lat = 1; req_i = 1'b1;
    do_branch(32'h700);
    repeat (6) tick();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/riscv_prefetch_queue.md
RISCV_PREFETCH_QUEUE -- requirements
Module: riscv_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-002 Parameter MAX_OUTSTANDING, default 2: maximum granted-but-unanswered requests; 1..DEPTH.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_i  input  1  fetching enabled.
REQ-006 branch_i  input  1  redirect fetch; addr_i  input  32  redirect target.
REQ-007 ready_i  input  1  consumer accepts the head entry; valid_o  output  1  head entry valid.
REQ-008 rdata_o  output  32  head instruction word; addr_o  output  32  word-aligned head address; err_o  output  1  head fetch error.
REQ-009 instr_req_o  output  1 / instr_addr_o  output  32 / instr_gnt_i  input  1 / instr_rvalid_i  input  1 / instr_rdata_i  input  32 / instr_err_i  input  1: memory port, one request per grant, in-order responses.
REQ-010 busy_o  output  1  outstanding requests exist or instr_req_o is high.

Function
REQ-011 Request FSM SHALL have two states. IDLE -> WAIT_GNT when instr_req_o is high and instr_gnt_i is low. WAIT_GNT -> IDLE on instr_gnt_i.
REQ-012 In IDLE, instr_req_o SHALL be req_i & (outstanding_cnt + fifo_cnt < DEPTH) & (outstanding_cnt < MAX_OUTSTANDING) (credit rule). Overflow is therefore impossible.
REQ-013 In WAIT_GNT, instr_req_o SHALL stay high and instr_addr_o SHALL stay stable until grant. The only exception is branch_i, which replaces the address in the same cycle.
REQ-014 instr_addr_o SHALL be {addr_i[31:2],2'b00} when branch_i is high, otherwise fetch_addr_q.
REQ-015 Each cycle with instr_req_o & instr_gnt_i SHALL increment outstanding_cnt and SHALL set fetch_addr_q to instr_addr_o + 4 (32-bit wrap, 0xFFFFFFFC -> 0x0).
REQ-016 Each instr_rvalid_i SHALL decrement outstanding_cnt. Grant and rvalid in the same cycle SHALL leave outstanding_cnt unchanged.
REQ-017 If discard_cnt > 0 on instr_rvalid_i, the response SHALL be dropped and discard_cnt decremented. Otherwise {instr_rdata_i, rsp_addr_q, err} SHALL be pushed and rsp_addr_q incremented by 4.
REQ-018 branch_i SHALL, in the same cycle:
- flush the FIFO;
- set fetch_addr_q and rsp_addr_q from the word-aligned addr_i;
- set discard_cnt to the outstanding count, excluding any rvalid in that cycle and excluding a grant in that cycle.
REQ-019 A grant in the branch cycle SHALL belong to the new target and SHALL NOT be discarded. An rvalid in the branch cycle SHALL be dropped.
REQ-020 valid_o SHALL be fifo_cnt != 0. Latency from instr_rvalid_i to valid_o SHALL be 1 cycle; there is no bypass.
REQ-021 ready_i & valid_o SHALL pop the head. Push and pop in the same cycle SHALL keep fifo_cnt unchanged. ready_i with empty FIFO SHALL be ignored.
REQ-022 req_i low SHALL stop new requests only; outstanding responses SHALL still be collected.
REQ-023 busy_o SHALL be (outstanding_cnt != 0) | instr_req_o.

Reset
REQ-024 rst SHALL return the block to its reset state at the next edge, including mid-transaction:
- FSM to IDLE;
- outstanding_cnt, discard_cnt and fifo_cnt to 0;
- fetch_addr_q and rsp_addr_q to 0.
REQ-025 While rst is high and on the first cycle after reset: instr_req_o=0, valid_o=0, err_o=0, busy_o=0. Responses arriving after reset SHALL be ignored (outstanding_cnt is 0).

Configuration
REQ-026 Macro PREFETCH_ERR_EN. When defined: instr_err_i is stored per entry and presented on err_o. After an errored response is pushed, no new request SHALL issue until branch_i. When undefined: err_o is tied 0, instr_err_i is unused, and no error bit is stored.

Structure
REQ-027 Package riscv_prefetch_pkg SHALL hold:
- the FSM state enum;
- the FIFO entry struct (rdata, addr, err);
- the width function for the counters.
REQ-028 The FIFO SHALL be a sub-module riscv_prefetch_fifo (DEPTH-parameterised, with clear, push, pop and count).

Verification
REQ-029 Bench SHALL cover the following directed scenarios:
- Branch to 0x100, gnt always 1, rvalid 1 cycle later, ready_i=1: addr_o sequence 0x100, 0x104, 0x108; valid_o first high 3 cycles after branch.
- ready_i=0, DEPTH=4: at most 4 grants issued; then instr_req_o=0 with fifo_cnt=4; one pop -> exactly one new request.
- Two outstanding (0x200, 0x204), branch to 0x300 before rvalid: both responses dropped; first valid_o shows addr_o=0x300.
- gnt low 5 cycles with branch to 0x400 on cycle 3: instr_addr_o switches to 0x400 and is held stable until grant.
- PREFETCH_ERR_EN defined, instr_err_i=1 on 0x10C: err_o=1 with addr_o=0x10C; no further request until branch.
- rst asserted with 2 outstanding: next cycle valid_o=0, busy_o=0; late rvalids produce no push.
